hood_timer_ctrl: RTL and testbench

Countdown timer controller for the kitchen hood. It owns the seconds prescaler, which divides the system clock to a 1 Hz tick. It sequences a loadable seconds countdown through run, pause and cancel commands from the panel FSM. On expiry it reports a one-cycle `done` to the fan/light controller, which then switches the hood off or changes mode.

---
 rtl/hood_timer_ctrl.sv | 156 +++++++++++++++
 tb/tb_hood_timer_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_timer_ctrl.sv
// Kitchen hood countdown timer: divides clk to a TICK_HZ tick and counts a loaded seconds value down to zero.
// Latency: commands act on the accepting edge; every output is registered and valid the cycle after that edge.
// Backpressure: none; start/pause/cancel are one-cycle pulses, and a command that is not legal in the current state is dropped.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   load_val       countdown start value (seconds), sampled with an accepted start from IDLE
//   start          start from IDLE / resume from PAUSED
//   pause          pause while running
//   cancel         abort from any state (no done)
//   remaining      seconds left
//   busy / paused  state is RUN or PAUSED / state is PAUSED
//   sec_tick       one-cycle pulse per decrement
//   done           one-cycle pulse on natural expiry
//   warn           near-expiry flag; only built when HOOD_TIMER_WARN_EN is defined, else constant 0
//
// Optional feature macro: HOOD_TIMER_WARN_EN

module hood_timer_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 1,
    parameter int CNT_W     = 12,
    parameter int WARN_SECS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             cancel,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused,
    output logic             sec_tick,
    output logic             done,
    output logic             warn
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [PS_W-1:0]  ps, ps_n;
    logic [CNT_W-1:0] rem_n;
    logic             tick_n;
    logic             done_n;
    logic             final_tick;

    // The prescaler only advances on RUN edges, including the edge that accepts
    // a pause; the resume edge itself is a PAUSED edge and does not advance it.
    // That makes every later tick shift by exactly (resume edge - pause edge).
    always_comb begin
        state_n    = state;
        ps_n       = ps;
        rem_n      = remaining;
        tick_n     = 1'b0;
        done_n     = 1'b0;
        final_tick = 1'b0;

        if (cancel) begin
            state_n = S_IDLE;
            ps_n    = '0;
            rem_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // A concurrent pause outranks start, and pause does nothing here.
                    if (start && !pause && (load_val != '0)) begin
                        state_n = S_RUN;
                        ps_n    = '0;
                        rem_n   = load_val;
                    end
                end
                S_RUN: begin
                    if (ps == PS_LAST) begin
                        ps_n   = '0;
                        tick_n = 1'b1;
                        rem_n  = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            final_tick = 1'b1;
                            done_n     = 1'b1;
                            state_n    = S_IDLE;
                        end
                    end else begin
                        ps_n = ps + PS_W'(1);
                    end
                    // The tick's effect lands first; a final tick beats the pause.
                    if (pause && !final_tick) begin
                        state_n = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (start && !pause) begin
                        state_n = S_RUN;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    ps_n    = '0;
                    rem_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ps        <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            sec_tick  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ps        <= ps_n;
            remaining <= rem_n;
            busy      <= (state_n != S_IDLE);
            paused    <= (state_n == S_PAUSED);
            sec_tick  <= tick_n;
            done      <= done_n;
        end
    end

`ifdef HOOD_TIMER_WARN_EN
    // Computed from next-state values so warn moves in the same cycle as remaining.
    logic warn_n;

    always_comb begin
        warn_n = (state_n != S_IDLE) &&
                 (rem_n >= CNT_W'(1)) &&
                 (rem_n <= CNT_W'(WARN_SECS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= warn_n;
        end
    end
`else
    // Feature not built: warn is a constant 0. WARN_SECS is still referenced so
    // both builds share one parameter list without an unused-parameter lint.
    assign warn = 1'b0 && (WARN_SECS != 0);
`endif

endmodule

// File: tb/tb_hood_timer_ctrl.sv
module tb_hood_timer_ctrl;

    localparam int DIV   = 10;
    localparam int CNT_W = 12;
    localparam int WARN  = 2;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] load_val;
    logic             start;
    logic             pause;
    logic             cancel;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;
    logic             sec_tick;
    logic             done;
    logic             warn;

    int checks   = 0;
    int failures = 0;

    hood_timer_ctrl #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .CNT_W    (CNT_W),
        .WARN_SECS(WARN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .cancel   (cancel),
        .remaining(remaining),
        .busy     (busy),
        .paused   (paused),
        .sec_tick (sec_tick),
        .done     (done),
        .warn     (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {remaining, busy, paused, sec_tick, done, warn}.
    wire [CNT_W+4:0] obs = {remaining, busy, paused, sec_tick, done, warn};

    // Reference model: the timer is described by how many running clock edges
    // have elapsed since the load. A second passes every DIV running edges and
    // remaining is simply load minus whole seconds elapsed.
    bit               m_active;
    bit               m_held;
    int               m_load;
    int               m_elapsed;
    logic [CNT_W+4:0] exp_v;

    function automatic void model_publish(bit tk, bit dn);
        logic [CNT_W-1:0] r;
        bit               w;
        r = m_active ? CNT_W'(m_load - m_elapsed / DIV) : '0;
        w = 1'b0;
`ifdef HOOD_TIMER_WARN_EN
        w = m_active && (r >= 1) && (r <= WARN);
`endif
        exp_v = {r, m_active, m_active && m_held, tk, dn, w};
    endfunction

    function automatic void model_reset();
        m_active  = 0;
        m_held    = 0;
        m_load    = 0;
        m_elapsed = 0;
        model_publish(0, 0);
    endfunction

    function automatic void model_edge(bit st, bit pa, bit ca, int lv);
        bit tk;
        bit dn;
        tk = 0;
        dn = 0;
        if (ca) begin
            m_active = 0;
            m_held   = 0;
        end else if (!m_active) begin
            if (st && !pa && lv != 0) begin
                m_active  = 1;
                m_held    = 0;
                m_load    = lv;
                m_elapsed = 0;
            end
        end else if (!m_held) begin
            m_elapsed++;
            if (m_elapsed % DIV == 0) begin
                tk = 1;
                if (m_load == m_elapsed / DIV) begin
                    dn       = 1;
                    m_active = 0;
                end
            end
            if (pa && m_active) m_held = 1;
        end else begin
            if (st && !pa) m_held = 0;
        end
        model_publish(tk, dn);
    endfunction

    // Drive one cycle of commands, let the edge happen, advance the model,
    // then release the pulses 1 ns after the edge.
    task automatic step(input bit st, input bit pa, input bit ca, input int lv);
        start    = st;
        pause    = pa;
        cancel   = ca;
        load_val = CNT_W'(lv);
        @(posedge clk);
        model_edge(st, pa, ca, lv);
        #1;
        start  = 1'b0;
        pause  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        cancel   = 1'b0;
        load_val = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        rst = 1'b0;
        step(0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_countdown();
        int n_tick;
        int done_k;
        int n_done;
        n_tick = 0;
        done_k = -1;
        n_done = 0;
        step(1, 0, 0, 3);
        checks++;
        if (remaining !== 12'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL countdown_load got rem=%0d busy=%b want rem=3 busy=1", remaining, busy);
        end
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL countdown k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (sec_tick) n_tick++;
            if (done) begin
                n_done++;
                done_k = k;
            end
        end
        checks++;
        if (n_tick !== 3 || n_done !== 1 || done_k !== 30) begin
            failures++;
            $display("FAIL countdown_timing got ticks=%0d dones=%0d done_at=%0d want 3/1/30", n_tick, n_done, done_k);
        end
    endtask

    task automatic test_idle_ignores();
        int seen;
        seen = 0;
        step(1, 0, 0, 0);
        checks++;
        if (obs !== exp_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_load got=%h want=%h", obs, exp_v);
        end
        step(0, 1, 0, 0);
        checks++;
        if (obs !== exp_v || paused !== 1'b0) begin
            failures++;
            $display("FAIL idle_pause got=%h want=%h", obs, exp_v);
        end
        // pause outranks start, so this start must not act
        step(1, 1, 0, 5);
        checks++;
        if (obs !== exp_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_pause_start got=%h want=%h", obs, exp_v);
        end
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 0, 0);
            if (sec_tick || done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL idle_quiet got activity=%0d want 0", seen);
        end
    endtask

    task automatic test_pause_resume();
        int t1;
        int t2;
        int done_k;
        int n_paused;
        t1 = -1;
        t2 = -1;
        done_k = -1;
        n_paused = 0;
        step(1, 0, 0, 2);
        for (int k = 1; k <= 50; k++) begin
            step(0, (k == 14), 0, 0);
            if (k == 30) begin
                // resume: issue start on edge E+30 (previous step already happened at k)
            end
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL pause_resume k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (sec_tick) begin
                if (t1 < 0) t1 = k;
                else t2 = k;
            end
            if (done) done_k = k;
            if (paused) n_paused++;
            if (k == 29) begin
                k++;
                step(1, 0, 0, 7);
                checks++;
                if (obs !== exp_v || paused !== 1'b0 || remaining !== 12'd1) begin
                    failures++;
                    $display("FAIL resume_edge got=%h want=%h", obs, exp_v);
                end
            end
        end
        checks++;
        if (t1 !== 10 || t2 !== 36 || done_k !== 36 || n_paused !== 16) begin
            failures++;
            $display("FAIL pause_timing got t1=%0d t2=%0d done=%0d paused=%0d want 10/36/36/16", t1, t2, done_k, n_paused);
        end
    endtask

    task automatic test_final_collisions();
        step(1, 0, 0, 1);
        repeat (9) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        checks++;
        if (done !== 1'b1 || paused !== 1'b0 || busy !== 1'b0 || obs !== exp_v) begin
            failures++;
            $display("FAIL pause_on_final got done=%b paused=%b busy=%b want 1/0/0", done, paused, busy);
        end
        step(1, 0, 0, 1);
        repeat (9) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        checks++;
        if (done !== 1'b0 || remaining !== '0 || busy !== 1'b0 || obs !== exp_v) begin
            failures++;
            $display("FAIL cancel_on_final got done=%b rem=%0d busy=%b want 0/0/0", done, remaining, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int n_done;
        n_done = 0;
        step(1, 0, 0, 5);
        repeat (14) step(0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_midrun got=%h want=0", obs);
        end
        #5;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 0, 0);
            if (done) n_done++;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL after_reset k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL reset_no_done got dones=%0d want 0", n_done);
        end
    endtask

    task automatic test_warn();
        int rise;
        int fall;
        int n_warn;
        bit prev;
        rise = -1;
        fall = -1;
        n_warn = 0;
        prev = 1'b0;
        step(1, 0, 0, 4);
        for (int k = 1; k <= 45; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL warn k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (warn && !prev) rise = k;
            if (!warn && prev) fall = k;
            if (warn) n_warn++;
            prev = warn;
        end
`ifdef HOOD_TIMER_WARN_EN
        checks++;
        if (rise !== 20 || fall !== 40) begin
            failures++;
            $display("FAIL warn_window got rise=%0d fall=%0d want 20/40", rise, fall);
        end
`else
        checks++;
        if (n_warn !== 0) begin
            failures++;
            $display("FAIL warn_off got high_cycles=%0d want 0", n_warn);
        end
`endif
    endtask

    task automatic test_random();
        bit st;
        bit pa;
        bit ca;
        int lv;
        int bad;
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 15) == 0);
            ca = ($urandom_range(0, 63) == 0);
            lv = $urandom_range(0, 6);
            step(st, pa, ca, lv);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random k=%0d cmd=%b%b%b lv=%0d got=%h want=%h", k, st, pa, ca, lv, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_idle_ignores();
        test_pause_resume();
        test_final_collisions();
        test_reset_midrun();
        test_warn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
